// File: rtl/cpu_prog_loader.sv
// Boot loader: takes a little-endian byte stream (header, imem words, dmem words,
// checksum), writes each word to the CPU memory ports and enables the CPU on a good checksum.
module cpu_prog_loader #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned ADDR_STEP  = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error,
  output logic [2:0]  state_dbg
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready;
  // in_ready is registered and high only while the loader consumes stream bytes.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_IMEM = 3'd2,
    S_DMEM = 3'd3,
    S_CSUM = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [15:0] imem_cnt_q, imem_cnt_d;
  logic [15:0] dmem_cnt_q, dmem_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [31:0] csum_q, csum_d;
  logic [31:0] addr_ext_q, addr_ext_d, wdata_ext_q, wdata_ext_d;
  logic [31:0] addr_ext_2_q, addr_ext_2_d, wdata_ext_2_q, wdata_ext_2_d;
  logic        wen_ext_q, wen_ext_d, wen_ext_2_q, wen_ext_2_d;
  logic        in_ready_q, in_ready_d;
  logic        cpu_enable_q, cpu_enable_d;
  logic        error_q, error_d;

  logic        accept;
  logic        word_done;
  logic [31:0] word_next;
  logic [31:0] word_addr;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    imem_cnt_d    = imem_cnt_q;
    dmem_cnt_d    = dmem_cnt_q;
    word_cnt_d    = word_cnt_q;
    csum_d        = csum_q;
    addr_ext_d    = addr_ext_q;
    wdata_ext_d   = wdata_ext_q;
    addr_ext_2_d  = addr_ext_2_q;
    wdata_ext_2_d = wdata_ext_2_q;
    wen_ext_d     = 1'b0;
    wen_ext_2_d   = 1'b0;

    accept    = in_valid && in_ready_q;
    // Little-endian: each new byte enters at the top, so after four bytes
    // the first byte received sits in bits [7:0].
    word_next = {in_data, shift_q[31:8]};
    word_done = accept && (byte_cnt_q == 2'd3);
    word_addr = 32'(word_cnt_q) * ADDR_STEP;

    if (accept) begin
      shift_d    = word_next;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
          csum_d     = 32'd0;
        end
      end
      S_HDR: begin
        if (word_done) begin
          imem_cnt_d = word_next[15:0];
          dmem_cnt_d = word_next[31:16];
          if (32'(word_next[15:0]) > IMEM_WORDS || 32'(word_next[31:16]) > DMEM_WORDS)
            state_d = S_ERR;
          else if (word_next[15:0] != 16'd0)
            state_d = S_IMEM;
          else if (word_next[31:16] != 16'd0)
            state_d = S_DMEM;
          else
            state_d = S_CSUM;
        end
      end
      S_IMEM: begin
        if (word_done) begin
          wen_ext_d   = 1'b1;
          wdata_ext_d = word_next;
          addr_ext_d  = word_addr;
          csum_d      = csum_q + word_next;
          if (word_cnt_q == imem_cnt_q - 16'd1) begin
            word_cnt_d = 16'd0;
            state_d    = (dmem_cnt_q != 16'd0) ? S_DMEM : S_CSUM;
          end else begin
            word_cnt_d = word_cnt_q + 16'd1;
          end
        end
      end
      S_DMEM: begin
        if (word_done) begin
          wen_ext_2_d   = 1'b1;
          wdata_ext_2_d = word_next;
          addr_ext_2_d  = word_addr;
          csum_d        = csum_q + word_next;
          if (word_cnt_q == dmem_cnt_q - 16'd1) begin
            word_cnt_d = 16'd0;
            state_d    = S_CSUM;
          end else begin
            word_cnt_d = word_cnt_q + 16'd1;
          end
        end
      end
      S_CSUM: begin
        if (word_done) state_d = (word_next == csum_q) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        if (halt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    in_ready_d   = (state_d == S_HDR) || (state_d == S_IMEM) ||
                   (state_d == S_DMEM) || (state_d == S_CSUM);
    cpu_enable_d = (state_d == S_RUN);
    error_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= 2'd0;
      shift_q       <= 32'd0;
      imem_cnt_q    <= 16'd0;
      dmem_cnt_q    <= 16'd0;
      word_cnt_q    <= 16'd0;
      csum_q        <= 32'd0;
      addr_ext_q    <= 32'd0;
      wdata_ext_q   <= 32'd0;
      addr_ext_2_q  <= 32'd0;
      wdata_ext_2_q <= 32'd0;
      wen_ext_q     <= 1'b0;
      wen_ext_2_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      cpu_enable_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      imem_cnt_q    <= imem_cnt_d;
      dmem_cnt_q    <= dmem_cnt_d;
      word_cnt_q    <= word_cnt_d;
      csum_q        <= csum_d;
      addr_ext_q    <= addr_ext_d;
      wdata_ext_q   <= wdata_ext_d;
      addr_ext_2_q  <= addr_ext_2_d;
      wdata_ext_2_q <= wdata_ext_2_d;
      wen_ext_q     <= wen_ext_d;
      wen_ext_2_q   <= wen_ext_2_d;
      in_ready_q    <= in_ready_d;
      cpu_enable_q  <= cpu_enable_d;
      error_q       <= error_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = in_ready_q;
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_ext_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_ext_q;
  assign addr_ext_2  = addr_ext_2_q;
  assign wen_ext_2   = wen_ext_2_q;
  assign ren_ext_2   = 1'b0;
  assign wdata_ext_2 = wdata_ext_2_q;
  assign cpu_enable  = cpu_enable_q;
  assign error       = error_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Randomized bench for cpu_prog_loader: images are built from word lists, the
// expected memory writes are queued from the stream format and checked by a monitor.
module tb_cpu_prog_loader;

  logic        clk = 1'b0;
  logic        arst_n, start, halt, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic        cpu_enable, busy, error;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_i_q[$];
  logic [63:0] exp_d_q[$];
  logic [31:0] img_i[$];
  logic [31:0] img_d[$];

  always #5 clk = ~clk;

  cpu_prog_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start), .halt(halt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .error(error),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [63:0] e;
    if (arst_n && wen_ext) begin
      if (exp_i_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL imem_unexpected_write: got addr 0x%08h data 0x%08h expected none", addr_ext, wdata_ext);
      end else begin
        e = exp_i_q.pop_front();
        chk("imem_addr", addr_ext, e[63:32]);
        chk("imem_data", wdata_ext, e[31:0]);
      end
    end
    if (arst_n && wen_ext_2) begin
      if (exp_d_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dmem_unexpected_write: got addr 0x%08h data 0x%08h expected none", addr_ext_2, wdata_ext_2);
      end else begin
        e = exp_d_q.pop_front();
        chk("dmem_addr", addr_ext_2, e[63:32]);
        chk("dmem_data", wdata_ext_2, e[31:0]);
      end
    end
    if (arst_n) begin
      checks++;
      if (ren_ext !== 1'b0 || ren_ext_2 !== 1'b0) begin
        errors++;
        $display("FAIL ren_tied: got %b/%b expected 0/0", ren_ext, ren_ext_2);
      end
    end
  end

  // Drives one byte, optionally after random bubbles; returns at posedge+1 after transfer.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) while ($urandom_range(1, 0) == 1) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    chk("in_ready_during_load", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // sel: 0 none, 1 expect imem strobe, 2 expect dmem strobe right after the last byte.
  task automatic send_word(input logic [31:0] w, input bit gaps, input int sel);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    if (sel == 1) chk("imem_strobe_latency", {31'd0, wen_ext}, 32'd1);
    if (sel == 2) chk("dmem_strobe_latency", {31'd0, wen_ext_2}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_clears_error", {31'd0, error}, 32'd0);
    chk("start_enters_load", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Loads img_i/img_d with the given header counts and checksum; the outcome is
  // predicted from the size limits and the 32-bit wrapped sum of all words.
  task automatic run_image(input logic [15:0] ic, input logic [15:0] dc,
                           input logic [31:0] csum, input bit gaps);
    logic [31:0] sum;
    bit ok;
    pulse_start();
    send_word({dc, ic}, gaps, 0);
    if (ic > 16'd512 || dc > 16'd1024) begin
      @(negedge clk);
      chk("hdr_err_error", {31'd0, error}, 32'd1);
      chk("hdr_err_ready", {31'd0, in_ready}, 32'd0);
      chk("hdr_err_enable", {31'd0, cpu_enable}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      return;
    end
    sum = 32'd0;
    for (int k = 0; k < img_i.size(); k++) begin
      exp_i_q.push_back({32'(k) * 32'd4, img_i[k]});
      sum += img_i[k];
    end
    for (int k = 0; k < img_d.size(); k++) begin
      exp_d_q.push_back({32'(k) * 32'd4, img_d[k]});
      sum += img_d[k];
    end
    ok = (sum == csum);
    foreach (img_i[k]) send_word(img_i[k], gaps, 1);
    foreach (img_d[k]) send_word(img_d[k], gaps, 2);
    send_word(csum, gaps, 0);
    @(negedge clk);
    chk("cpu_enable_after_csum", {31'd0, cpu_enable}, {31'd0, ok});
    chk("error_after_csum", {31'd0, error}, {31'd0, !ok});
    chk("ready_after_csum", {31'd0, in_ready}, 32'd0);
    chk("imem_writes_left", exp_i_q.size(), 32'd0);
    chk("dmem_writes_left", exp_d_q.size(), 32'd0);
    exp_i_q.delete();
    exp_d_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    @(negedge clk);
    chk("halt_enable_off", {31'd0, cpu_enable}, 32'd0);
    chk("halt_to_idle", {29'd0, state_dbg}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic set_image_a();
    img_i = '{32'h2008_0005, 32'h0109_4020};
    img_d = '{32'h0000_002A};
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_enable"}, {31'd0, cpu_enable}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, wen_ext, wen_ext_2}, 32'd0);
    chk({tag, "_addr"}, addr_ext | addr_ext_2, 32'd0);
    chk({tag, "_data"}, wdata_ext | wdata_ext_2, 32'd0);
    chk({tag, "_state"}, {29'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    logic [31:0] s;
    int ni, nd;
    arst_n = 1'b0; start = 1'b0; halt = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Reference image, no bubbles, good checksum.
    set_image_a();
    run_image(16'd2, 16'd1, 32'h2111_404F, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_ignored_in_run", {31'd0, cpu_enable}, 32'd1);
    @(posedge clk); #1;
    do_halt();

    // Wrong checksum, then recovery from ERR with bubbles.
    run_image(16'd2, 16'd1, 32'h0000_0000, 1'b0);
    run_image(16'd2, 16'd1, 32'h2111_404F, 1'b1);
    do_halt();

    // Oversized headers.
    img_i.delete(); img_d.delete();
    run_image(16'd513, 16'd0, 32'd0, 1'b0);
    run_image(16'd0, 16'd1025, 32'd0, 1'b1);

    // Empty image.
    run_image(16'd0, 16'd0, 32'd0, 1'b0);
    do_halt();

    // Random images; roughly one in four carries a corrupted checksum.
    for (int t = 0; t < 8; t++) begin
      img_i.delete(); img_d.delete();
      ni = $urandom_range(6, 0);
      nd = $urandom_range(6, 0);
      s = 32'd0;
      for (int k = 0; k < ni; k++) begin img_i.push_back($urandom()); s += img_i[k]; end
      for (int k = 0; k < nd; k++) begin img_d.push_back($urandom()); s += img_d[k]; end
      if ($urandom_range(3, 0) == 0) s = s ^ (32'd1 << $urandom_range(31, 0));
      run_image(16'(ni), 16'(nd), s, 1'($urandom_range(1, 0)));
      if (cpu_enable) do_halt();
    end

    // Reset after the first imem word has been written.
    set_image_a();
    pulse_start();
    send_word({16'd1, 16'd2}, 1'b0, 0);
    exp_i_q.push_back({32'd0, 32'h2008_0005});
    send_word(32'h2008_0005, 1'b0, 1);
    @(posedge clk); #1;
    chk("first_word_written", exp_i_q.size(), 32'd0);
    arst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midload_reset");
    arst_n = 1'b1;
    exp_i_q.delete(); exp_d_q.delete();
    @(posedge clk); #1;

    // Normal reload after the abandoned one.
    run_image(16'd2, 16'd1, 32'h2111_404F, 1'b1);
    do_halt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cpu_prog_loader.md
Name: cpu_prog_loader

Overview:
- Upstream boot block for the pipelined CPU.
- Accepts a byte stream (valid/ready) carrying a program image and writes it word-by-word into instruction memory and data memory through the CPU external ports.
- Verifies a trailing checksum, then asserts the CPU enable.
- Holds the CPU disabled while loading, and permanently on checksum or size error.

Parameters:
- IMEM_WORDS, 512, instruction memory depth in words; larger header counts are errors.
- DMEM_WORDS, 1024, data memory depth in words.
- ADDR_STEP, 4, address increment per written word (byte addressing).

Ports:
- clk  in  1  main clock
- arst_n  in  1  reset, synchronous, active-low
- start  in  1  begin load; sampled only in IDLE
- halt  in  1  leave RUN, drop cpu_enable, return to IDLE
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle
- addr_ext  out  32  instruction memory write address
- wen_ext  out  1  instruction memory write strobe
- ren_ext  out  1  tied 0
- wdata_ext  out  32  instruction memory write word
- addr_ext_2  out  32  data memory write address
- wen_ext_2  out  1  data memory write strobe
- ren_ext_2  out  1  tied 0
- wdata_ext_2  out  32  data memory write word
- cpu_enable  out  1  drives CPU enable
- busy  out  1  high in HDR/IMEM/DMEM/CSUM
- error  out  1  sticky until next start or reset

Behaviour:
- Reset (arst_n=0 at a rising clk edge): state=IDLE. All outputs 0, including addresses, data, strobes, cpu_enable, error, in_ready. Byte counter, word counters and checksum cleared. Reset asserted mid-load abandons the load; memory writes already done are not undone.
- Byte transfer occurs on an edge where in_valid && in_ready. in_ready=1 exactly in HDR, IMEM, DMEM, CSUM.
- Stream format, all little-endian:
  - 2 bytes imem_cnt
  - 2 bytes dmem_cnt
  - imem_cnt words
  - dmem_cnt words
  - 4-byte checksum = sum mod 2^32 of all imem and dmem words (header excluded)
- FSM states:
  - IDLE: start=1 -> HDR; clears error, checksum, counters.
  - HDR: collect 4 bytes. After the 4th byte:
    - imem_cnt>IMEM_WORDS or dmem_cnt>DMEM_WORDS -> ERR.
    - else imem_cnt>0 -> IMEM.
    - else dmem_cnt>0 -> DMEM.
    - else CSUM.
  - IMEM: assemble 4 bytes into a word. On the 4th byte, the next cycle presents:
    - wen_ext=1 for exactly one cycle
    - wdata_ext = word
    - addr_ext = k*ADDR_STEP, where k counts from 0
    - checksum += word
    - After word imem_cnt-1 -> DMEM if dmem_cnt>0, else CSUM.
  - DMEM: same as IMEM using the _2 ports. After word dmem_cnt-1 -> CSUM.
  - CSUM: collect 4 bytes. Equal to the running checksum -> RUN; else ERR.
  - RUN: cpu_enable=1 starting the cycle after the last checksum byte. halt=1 -> IDLE, with cpu_enable=0 the next cycle. start ignored.
  - ERR: error=1, cpu_enable=0, in_ready=0. start=1 -> HDR with error cleared.
- Write latency: strobe one cycle after the accepting edge of the final byte of a word. Back-to-back bytes are accepted every cycle with no stall. Address/data hold their last values when the strobe is 0.
- Bubbles (in_valid=0) pause byte assembly without losing partial words.
- halt outside RUN has no effect. start outside IDLE/ERR is ignored.
- Checksum addition wraps at 32 bits; no overflow flag.
- cpu_enable is 0 in every state except RUN.

Test Plan:
- Reset, start, stream 02 00 01 00, imem words 0x20080005 and 0x01094020, dmem word 0x0000002A, then checksum 0x2111404F (LE 4F 40 11 21):
  - wen_ext pulses twice at addr 0x0 and 0x4 with those data.
  - wen_ext_2 pulses once at addr 0x0 with 0x2A.
  - cpu_enable=1 after the last byte; error=0.
- Same image with checksum 0x00000000 -> all writes occur, state ERR, error=1, cpu_enable stays 0; a new start clears error.
- Header imem_cnt=0x0201 (513) -> ERR immediately after the 4th header byte; no write strobes.
- Header 00 00 00 00 then checksum 00 00 00 00 -> no writes, RUN, cpu_enable=1.
- Random in_valid gaps (≈50%) on the first image -> identical writes/addresses/data as the gap-free run; in_ready high throughout the load.
- Reset asserted after the first imem word is written -> next cycle all outputs 0, IDLE. halt in RUN -> cpu_enable 0 next cycle; later start reloads normally.
